// File: rtl/commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// commit_trace_buffer
//
// Captures every retired instruction from the write-back commit stream into a
// circular FIFO. Each entry is tagged with a sequence number, and the FIFO is
// drained over a valid/ready port to a trace sink. The block also counts
// retired instructions, records dropped commits when the FIFO is full, and
// stops capturing once the halt instruction has been committed.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   HALT_INST  instruction word that stops capture (default: ebreak)
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous, active-high reset
//   commit_wb        an instruction retires this cycle
//   pc_cur           PC of the retiring instruction
//   inst             instruction word of the retiring instruction
//   uncache_read_wb  the retiring instruction was an uncached load
//   trace_valid      head entry available
//   trace_ready      sink accepts the head entry
//   trace_pc         head entry PC                  (0 while trace_valid=0)
//   trace_inst       head entry instruction         (0 while trace_valid=0)
//   trace_uncache    head entry uncached-load flag  (0 while trace_valid=0)
//   trace_seq        head entry sequence number     (0 while trace_valid=0)
//   count            current occupancy
//   overflow         sticky, set on the first dropped commit
//   drop_cnt         dropped commits, saturating at 16'hFFFF
//   instret          accepted plus dropped commits, wraps
//   halted           HALT_INST has been committed
// ---------------------------------------------------------------------------
module commit_trace_buffer #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] HALT_INST = 32'h0010_0073
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_wb,
    input  logic [31:0]            pc_cur,
    input  logic [31:0]            inst,
    input  logic                   uncache_read_wb,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic [31:0]            trace_inst,
    output logic                   trace_uncache,
    output logic [31:0]            trace_seq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    output logic [31:0]            instret,
    output logic                   halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        uncache;
        logic [31:0] seq;
    } entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q,     head_d;
    logic [PTR_W-1:0] tail_q,     tail_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [31:0]      instret_q,  instret_d;
    logic             halted_q,   halted_d;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic   commit_ev;
    logic   full;
    logic   pop;
    logic   push;
    logic   drop;
    entry_t new_entry;
    entry_t head_entry;

    assign full = (count_q == FULL_COUNT);

    // The reset cycle must never carry a handshake or a capture, so rst
    // masks the valid flag and the commit event directly.
    assign trace_valid = (count_q != '0) && !rst;
    assign commit_ev   = commit_wb && !halted_q && !rst;

    assign pop  = trace_valid && trace_ready;
    // When full, a pop in the same cycle frees the head slot, so the push
    // still lands without a drop.
    assign push = commit_ev && (!full || pop);
    assign drop = commit_ev && full && !pop;

    assign new_entry = '{pc:      pc_cur,
                         inst:    inst,
                         uncache: uncache_read_wb,
                         seq:     instret_q};

    assign head_entry = mem_q[head_q];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every value driven here gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        instret_d  = instret_q;
        halted_d   = halted_q;

        // DEPTH is a power of two, so PTR_W-bit increments wrap DEPTH-1 -> 0.
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (commit_ev) begin
            instret_d = instret_q + 32'd1;
            if (inst == HALT_INST) begin
                halted_d = 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            instret_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            instret_q  <= instret_d;
            halted_q   <= halted_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it was written, and count gates every read, so stale
    // contents are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= new_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Head fields are forced to zero while nothing is presented, which keeps
    // the sink from ever seeing stale or uninitialised storage.
    always_comb begin
        trace_pc      = '0;
        trace_inst    = '0;
        trace_uncache = 1'b0;
        trace_seq     = '0;
        if (trace_valid) begin
            trace_pc      = head_entry.pc;
            trace_inst    = head_entry.inst;
            trace_uncache = head_entry.uncache;
            trace_seq     = head_entry.seq;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign instret  = instret_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Self-checking bench for commit_trace_buffer. The driver issues one cycle of
// stimulus at a time, advances a queue-based reference model and pushes every
// entry the sink should eventually receive into a scoreboard. A separate
// monitor on the falling edge compares the presented head entry against the
// scoreboard front, pops it on a handshake, and checks the status outputs
// against a snapshot of the model taken for that cycle.
// ---------------------------------------------------------------------------
module tb_commit_trace_buffer;

    localparam int          DEPTH     = 16;
    localparam logic [31:0] HALT_INST = 32'h0010_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic                   clk;
    logic                   rst;
    logic                   commit_wb;
    logic [31:0]            pc_cur;
    logic [31:0]            inst;
    logic                   uncache_read_wb;
    logic                   trace_valid;
    logic                   trace_ready;
    logic [31:0]            trace_pc;
    logic [31:0]            trace_inst;
    logic                   trace_uncache;
    logic [31:0]            trace_seq;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [15:0]            drop_cnt;
    logic [31:0]            instret;
    logic                   halted;

    commit_trace_buffer #(
        .DEPTH     (DEPTH),
        .HALT_INST (HALT_INST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .commit_wb       (commit_wb),
        .pc_cur          (pc_cur),
        .inst            (inst),
        .uncache_read_wb (uncache_read_wb),
        .trace_valid     (trace_valid),
        .trace_ready     (trace_ready),
        .trace_pc        (trace_pc),
        .trace_inst      (trace_inst),
        .trace_uncache   (trace_uncache),
        .trace_seq       (trace_seq),
        .count           (count),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt),
        .instret         (instret),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        unc;
        logic [31:0] seq;
    } ent_t;

    // Reference model: FIFO contents plus the counters, kept as plain values.
    ent_t        m_q[$];
    int unsigned m_instret;
    int unsigned m_drop;
    bit          m_ovf;
    bit          m_halted;

    // Scoreboard of entries the sink is still owed, in delivery order.
    ent_t sb[$];

    // Expected status for the cycle currently being driven.
    bit          exp_valid;
    int unsigned exp_count;
    int unsigned exp_instret;
    int unsigned exp_drop;
    bit          exp_ovf;
    bit          exp_halted;

    int  tests;
    int  fails;
    bit  started;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Called just after a rising edge; inputs
    // stay stable through the falling edge (monitor) and the next rising edge.
    task automatic cyc(input bit r_st, input bit c, input logic [31:0] pc,
                       input logic [31:0] ins, input bit u, input bit rdy);
        bit   ev;
        bit   pop;
        ent_t e;
        exp_valid   = !r_st && (m_q.size() > 0);
        exp_count   = m_q.size();
        exp_instret = m_instret;
        exp_drop    = m_drop;
        exp_ovf     = m_ovf;
        exp_halted  = m_halted;

        rst             = r_st;
        commit_wb       = c;
        pc_cur          = pc;
        inst            = ins;
        uncache_read_wb = u;
        trace_ready     = rdy;

        ev  = !r_st && c && !m_halted;
        pop = !r_st && (m_q.size() > 0) && rdy;
        if (ev) begin
            e = '{pc: pc, inst: ins, unc: u, seq: m_instret};
            m_instret++;
            if (m_q.size() < DEPTH || pop) begin
                m_q.push_back(e);
                sb.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 16'hFFFF) m_drop++;
            end
            if (ins == HALT_INST) m_halted = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (r_st) begin
            m_q.delete();
            sb.delete();
            m_instret = 0;
            m_drop    = 0;
            m_ovf     = 1'b0;
            m_halted  = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_q.size() > 0; i++) idle(1, 1'b1);
        idle(1, 1'b1);
    endtask

    // Monitor: head entry against scoreboard, status against model snapshot.
    always @(negedge clk) begin
        if (started) begin
            check("trace_valid", {31'b0, trace_valid}, {31'b0, exp_valid});
            check("count",       32'(count),           32'(exp_count));
            check("instret",     instret,              exp_instret);
            check("drop_cnt",    {16'b0, drop_cnt},    exp_drop);
            check("overflow",    {31'b0, overflow},    {31'b0, exp_ovf});
            check("halted",      {31'b0, halted},      {31'b0, exp_halted});
            if (trace_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_entry_seq", trace_seq, 32'hFFFF_FFFF);
                end else begin
                    check("trace_pc",      trace_pc,                sb[0].pc);
                    check("trace_inst",    trace_inst,              sb[0].inst);
                    check("trace_uncache", {31'b0, trace_uncache},  {31'b0, sb[0].unc});
                    check("trace_seq",     trace_seq,               sb[0].seq);
                    if (trace_ready) void'(sb.pop_front());
                end
            end else begin
                check("idle_fields_zero", trace_pc | trace_inst | trace_seq | {31'b0, trace_uncache}, 32'h0);
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        started   = 1'b0;
        m_instret = 0;
        m_drop    = 0;
        m_ovf     = 1'b0;
        m_halted  = 1'b0;
        rst             = 1'b1;
        commit_wb       = 1'b0;
        pc_cur          = '0;
        inst            = '0;
        uncache_read_wb = 1'b0;
        trace_ready     = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;
        do_reset();

        // Single commit: visible the next cycle, then drained.
        cyc(1'b0, 1'b1, 32'h8000_0000, NOP, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Back-pressure then sustained push+pop with pointer wrap.
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 32'h8000_0000 + 4 * k, NOP, k[0], 1'b0);
        for (int k = 16; k < 36; k++) cyc(1'b0, 1'b1, 32'h8000_0000 + 4 * k, NOP, k[1], 1'b1);
        drain();

        // Overflow: two drops, seq gap visible to the sink.
        do_reset();
        for (int k = 0; k < 18; k++) cyc(1'b0, 1'b1, 32'h9000_0000 + 4 * k, NOP, 1'b0, 1'b0);
        check("ovf_drop_cnt", {16'b0, drop_cnt}, 32'd2);
        check("ovf_instret",  instret,           32'd18);
        drain();

        // Full with simultaneous push and pop.
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 32'hA000_0000 + 4 * k, NOP, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'hA000_1000, NOP, 1'b1, 1'b1);
        idle(1, 1'b0);
        drain();

        // Halt: third commit is ignored.
        do_reset();
        cyc(1'b0, 1'b1, 32'h8000_0000, NOP,       1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h8000_0004, HALT_INST, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h8000_0008, NOP,       1'b0, 1'b0);
        idle(2, 1'b0);
        check("halt_instret", instret, 32'd2);
        drain();

        // Reset mid-operation with entries queued and overflow set.
        do_reset();
        for (int k = 0; k < 17; k++) cyc(1'b0, 1'b1, 32'hB000_0000 + 4 * k, NOP, 1'b0, 1'b0);
        idle(11, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 32'hC000_0000, NOP, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Randomised traffic, with occasional halts and resets.
        for (int i = 0; i < 3000; i++) begin
            bit          c;
            bit          r;
            logic [31:0] ins;
            c   = ($urandom_range(0, 3) != 0);
            r   = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ins = ($urandom_range(0, 99) == 0) ? HALT_INST : $urandom;
            if ($urandom_range(0, 249) == 0) begin
                cyc(1'b1, c, $urandom, ins, 1'($urandom), r);
            end else begin
                cyc(1'b0, c, $urandom, ins, 1'($urandom), r);
            end
        end
        drain();
        idle(1, 1'b1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
